mem_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate data cache between MEM stage and SRAM_Controller.

---
 rtl/mem_cache_pkg.sv | 17 +
 rtl/mem_cache_if.sv | 23 ++
 rtl/mem_cache_array.sv | 45 ++++
 rtl/mem_cache.sv | 146 ++++++++++++++
 tb/tb_mem_cache.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the FSM state encoding, the default geometry and the word/line widths.
package mem_cache_pkg;

  localparam int DEF_INDEX_W = 6;
  localparam int DEF_TAG_W   = 10;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int OFFSET_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_THRU = 2'd2
  } state_t;

endpackage

// File: rtl/mem_cache_if.sv
// Upstream MEM-stage request/ready bus, the same shape the stage would present to SRAM.
// master = MEM stage side, slave = cache side.
interface mem_cache_if;
  import mem_cache_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/mem_cache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
// Valid bits have a synchronous clear; tag and data storage is never reset.
module mem_cache_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 10,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               i_clear,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [DATA_W-1:0]  o_rd_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]  i_wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of the SRAM controller.
// Optional read hit/miss counters are built only when CACHE_STATS_EN is defined.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  mem_cache_if.slave        mem_bus,
  output logic              o_sram_rd_en,
  output logic              o_sram_wr_en,
  output logic [ADDR_W-1:0] o_sram_address,
  output logic [DATA_W-1:0] o_sram_write_data,
  input  logic [DATA_W-1:0] i_sram_read_data,
  input  logic              i_sram_ready,
  output logic [31:0]       o_hit_count,
  output logic [31:0]       o_miss_count
);

  state_t r_state;
  state_t w_state_next;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_line_valid;
  logic [TAG_W-1:0]   w_line_tag;
  logic [DATA_W-1:0]  w_line_data;
  logic               w_hit;
  logic               w_read_hit;
  logic               w_arr_wr;
  logic               w_arr_wr_en;
  logic [DATA_W-1:0]  w_arr_wr_data;

  assign w_index = mem_bus.address[INDEX_W+1:OFFSET_W];
  assign w_tag   = mem_bus.address[INDEX_W+TAG_W+1:INDEX_W+2];
  assign w_hit   = w_line_valid && (w_line_tag == w_tag);

  // A fill or write-through completing in the reset cycle must not land in the array.
  assign w_arr_wr_en   = w_arr_wr && !rst;
  assign w_arr_wr_data = (r_state == ST_RD_MISS) ? i_sram_read_data : mem_bus.write_data;

  mem_cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk        (clk),
    .i_clear    (rst),
    .i_rd_index (w_index),
    .o_rd_valid (w_line_valid),
    .o_rd_tag   (w_line_tag),
    .o_rd_data  (w_line_data),
    .i_wr_en    (w_arr_wr_en),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (w_arr_wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    mem_bus.ready     = 1'b1;
    mem_bus.read_data = '0;
    o_sram_rd_en      = 1'b0;
    o_sram_wr_en      = 1'b0;
    w_arr_wr          = 1'b0;
    w_read_hit        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A simultaneous read and write is handled as a write.
        if (mem_bus.mem_write) begin
          mem_bus.ready = 1'b0;
          w_state_next  = ST_WR_THRU;
        end else if (mem_bus.mem_read) begin
          if (w_hit) begin
            mem_bus.read_data = w_line_data;
            w_read_hit        = 1'b1;
          end else begin
            mem_bus.ready = 1'b0;
            w_state_next  = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        o_sram_rd_en  = 1'b1;
        mem_bus.ready = 1'b0;
        if (i_sram_ready) begin
          w_arr_wr          = 1'b1;
          mem_bus.read_data = i_sram_read_data;
          mem_bus.ready     = 1'b1;
          w_state_next      = ST_IDLE;
        end
      end
      ST_WR_THRU: begin
        o_sram_wr_en  = 1'b1;
        mem_bus.ready = 1'b0;
        if (i_sram_ready) begin
          w_arr_wr      = w_hit;
          mem_bus.ready = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_sram_address    = mem_bus.address;
  assign o_sram_write_data = mem_bus.write_data;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_read_hit) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if ((r_state == ST_IDLE) && (w_state_next == ST_RD_MISS)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
`else
  assign o_hit_count  = '0;
  assign o_miss_count = '0;
`endif

endmodule

// File: tb/tb_mem_cache.sv
// Self-checking bench for mem_cache: SRAM model answering 5 cycles after an enable,
// transaction-level reference cache, directed scenarios followed by randomized traffic.
module tb_mem_cache;

  localparam int SRAM_LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_rd_en, sram_wr_en, sram_ready;
  logic [31:0] sram_address, sram_write_data;
  logic [31:0] sram_read_data = '0;
  logic [31:0] hit_count, miss_count;

  mem_cache_if bus ();

  mem_cache u_dut (
    .clk               (clk),
    .rst               (rst),
    .mem_bus           (bus.slave),
    .o_sram_rd_en      (sram_rd_en),
    .o_sram_wr_en      (sram_wr_en),
    .o_sram_address    (sram_address),
    .o_sram_write_data (sram_write_data),
    .i_sram_read_data  (sram_read_data),
    .i_sram_ready      (sram_ready),
    .o_hit_count       (hit_count),
    .o_miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM controller model
  logic [31:0] sram_mem [logic [29:0]];
  int unsigned sram_cnt = 0;

  assign sram_ready = (sram_rd_en || sram_wr_en) && (sram_cnt == SRAM_LAT - 1);

  always @(posedge clk) begin
    if (sram_rd_en || sram_wr_en) begin
      sram_cnt <= sram_cnt + 1;
      if (sram_mem.exists(sram_address[31:2]))
        sram_read_data <= sram_mem[sram_address[31:2]];
      else
        sram_read_data <= init_word(sram_address[31:2]);
      if (sram_wr_en && sram_ready)
        sram_mem[sram_address[31:2]] = sram_write_data;
    end else begin
      sram_cnt <= 0;
    end
  end

  // Reference model: a 64-line direct-mapped cache over a word memory
  bit          ref_valid [64];
  logic [9:0]  ref_tag   [64];
  logic [31:0] ref_data  [64];
  logic [31:0] ref_mem   [logic [29:0]];
  int unsigned ref_hits = 0;
  int unsigned ref_misses = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a[31:2]);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  // Entered and left at posedge+1; the request is held until ready is seen.
  task automatic cache_req(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int stalls,
                           output logic [31:0] rdata, output bit saw_rd,
                           output bit saw_wr, output logic [31:0] sram_addr_seen);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    stalls = 0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    rdata  = '0;
    sram_addr_seen = '0;
    forever begin
      @(negedge clk);
      saw_rd = saw_rd | sram_rd_en;
      saw_wr = saw_wr | sram_wr_en;
      if (bus.ready) begin
        rdata = bus.read_data;
        sram_addr_seen = sram_address;
        break;
      end
      stalls++;
      if (stalls > 40) begin
        chk("ready_timeout", 32'(stalls), 32'(SRAM_LAT));
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic txn(input string name, input bit rd, input bit wr,
                     input logic [31:0] addr, input logic [31:0] wdata);
    int          stalls;
    logic [31:0] rdata, sa;
    bit          saw_rd, saw_wr, hit, is_write;
    int          idx;
    logic [9:0]  tg;
    int          exp_stall;
    logic [31:0] exp_data;
    idx      = int'(addr[7:2]);
    tg       = addr[17:8];
    hit      = ref_valid[idx] && (ref_tag[idx] == tg);
    is_write = wr;
    if (is_write) begin
      exp_stall = SRAM_LAT;
      exp_data  = '0;
      ref_mem[addr[31:2]] = wdata;
      if (hit) ref_data[idx] = wdata;
    end else begin
      exp_stall = hit ? 0 : SRAM_LAT;
      exp_data  = hit ? ref_data[idx] : ref_word(addr);
      if (hit) begin
        ref_hits++;
      end else begin
        ref_misses++;
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tg;
        ref_data[idx]  = exp_data;
      end
    end
    cache_req(rd, wr, addr, wdata, stalls, rdata, saw_rd, saw_wr, sa);
    chk({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    if (!is_write) chk({name, "_rdata"}, rdata, exp_data);
    chk({name, "_sram_rd_en"}, 32'(saw_rd), 32'(!is_write && !hit));
    chk({name, "_sram_wr_en"}, 32'(saw_wr), 32'(is_write));
    chk({name, "_sram_addr"}, sa, addr);
`ifdef CACHE_STATS_EN
    chk({name, "_hit_count"}, hit_count, ref_hits);
    chk({name, "_miss_count"}, miss_count, ref_misses);
`else
    chk({name, "_hit_count"}, hit_count, 32'd0);
    chk({name, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    int          r;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    ref_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_rd_en", 32'(sram_rd_en), 32'd0);
    chk("rst_wr_en", 32'(sram_wr_en), 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    txn("cold_rd_400", 1, 0, 32'h400, '0);
    txn("hit_rd_400", 1, 0, 32'h400, '0);
    txn("wr_hit_400", 0, 1, 32'h400, 32'hDEAD_BEEF);
    txn("rd_after_wr_400", 1, 0, 32'h400, '0);
    txn("wr_miss_800", 0, 1, 32'h800, 32'h0BAD_F00D);
    txn("rd_noalloc_800", 1, 0, 32'h800, '0);
    txn("conf_rd_400", 1, 0, 32'h400, '0);
    txn("conf_rd_500", 1, 0, 32'h500, '0);
    txn("conf_rd_400b", 1, 0, 32'h400, '0);
    txn("both_high_wr", 1, 1, 32'h404, 32'h1234_5678);

    // reset two cycles into a read miss
    bus.mem_read = 1'b1;
    bus.address  = 32'hC00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_read = 1'b0;
    ref_reset();
    @(negedge clk);
    chk("abort_rd_en", 32'(sram_rd_en), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    @(posedge clk); #1;
    txn("reread_c00", 1, 0, 32'hC00, '0);
    txn("reread_400", 1, 0, 32'h400, '0);

    for (int i = 0; i < 300; i++) begin
      a = {14'd0, 8'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'd0};
      a = {a[31:4], a[3:2] ^ 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d = $urandom;
      r = $urandom_range(0, 9);
      if (r < 6)      txn("rnd_rd", 1, 0, a, d);
      else if (r < 9) txn("rnd_wr", 0, 1, a, d);
      else            txn("rnd_rdwr", 1, 1, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
